// File: rtl/keypad_scan_fifo.sv
// Row-scanned keypad controller: rotates a one-cold row drive, resolves one key per
// frame, debounces press/release over whole frames and queues press codes in a FIFO.
module keypad_scan_fifo #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 250000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [COLS-1:0]                 keypadCol,
  output logic [ROWS-1:0]                 keypadRow,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic                            key_held,
  output logic                            overflow,
  input  logic                            ovf_clear
);

  localparam int CW    = $clog2(ROWS*COLS);
  localparam int DIVW  = $clog2(SCAN_DIV);
  localparam int RW    = $clog2(ROWS);
  localparam int CNTW  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;

  logic [DIVW-1:0] div_q, div_d;
  logic [RW-1:0]   row_q, row_d;
  logic            acc_hit_q, acc_hit_d;
  logic [CW-1:0]   acc_code_q, acc_code_d;
  logic            frame_done_q, frame_done_d;
  state_e          state_q, state_d;
  logic [CW-1:0]   cand_q, cand_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]  count_q, count_d, residual;
  logic [CW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            overflow_q, overflow_d;
  logic [CW-1:0]   mem_q [FIFO_DEPTH];

  logic            tick, last_row, hit, push, pop, full, wr_en, drop;
  logic [CW-1:0]   row_code;
  int              hit_col;

  // Scan divider, row rotation and per-frame first-contact accumulator.
  always_comb begin
    tick     = (div_q == DIVW'(SCAN_DIV - 1));
    last_row = (row_q == RW'(ROWS - 1));
    div_d    = tick ? '0 : div_q + 1'b1;
    row_d    = row_q;
    if (tick) row_d = last_row ? '0 : row_q + 1'b1;

    hit     = 1'b0;
    hit_col = 0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!keypadCol[c]) begin
        hit     = 1'b1;
        hit_col = c;
      end
    end
    row_code = CW'(int'(row_q) * COLS + hit_col);

    acc_hit_d  = acc_hit_q;
    acc_code_d = acc_code_q;
    if (tick && (row_q == '0 || !acc_hit_q)) begin
      acc_hit_d  = hit;
      acc_code_d = row_code;
    end
    frame_done_d = tick && last_row;
    keypadRow    = ~(ROWS'(1) << row_q);
  end

  // Debounce FSM; acc_* hold the completed frame while frame_done_q is high.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (frame_done_q) begin
      unique case (state_q)
        IDLE: begin
          if (acc_hit_q) begin
            cand_d = acc_code_q;
            cnt_d  = CNTW'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = HELD;
              cnt_d   = '0;
              push    = 1'b1;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (!acc_hit_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (acc_code_q != cand_q) begin
            cand_d = acc_code_q;
            cnt_d  = CNTW'(1);
          end else if (int'(cnt_q) + 1 >= DEBOUNCE_FRAMES) begin
            state_d = HELD;
            cnt_d   = '0;
            push    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!acc_hit_q) begin
            state_d = (DEBOUNCE_FRAMES == 1) ? IDLE : REL_CHK;
            cnt_d   = (DEBOUNCE_FRAMES == 1) ? '0 : CNTW'(1);
          end
        end
        REL_CHK: begin
          if (acc_hit_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (int'(cnt_q) + 1 >= DEBOUNCE_FRAMES) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO control; the registered head is refilled from memory or from the bypassed push.
  always_comb begin
    pop      = key_valid_q && key_ready;
    full     = (count_q == FCW'(FIFO_DEPTH));
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    residual    = pop ? count_q - 1'b1 : count_q;
    key_valid_d = (count_d != '0);
    key_code_d  = key_code_q;
    if (residual != '0)  key_code_d = mem_q[rd_ptr_d];
    else if (wr_en)      key_code_d = acc_code_q;
    overflow_d = drop || (overflow_q && !ovf_clear);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q        <= '0;
      row_q        <= '0;
      acc_hit_q    <= 1'b0;
      acc_code_q   <= '0;
      frame_done_q <= 1'b0;
      state_q      <= IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      row_q        <= row_d;
      acc_hit_q    <= acc_hit_d;
      acc_code_q   <= acc_code_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: storage is not reset; reset empties the FIFO through its pointers and count.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= acc_code_q;
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD) || (state_q == REL_CHK);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Randomised bench for keypad_scan_fifo: an emulated key matrix drives the columns and a
// frame-level reference model predicts the outputs after every clock edge.
module tb_keypad_scan_fifo;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SDIV  = 4;
  localparam int DF    = 3;
  localparam int DEPTH = 4;

  logic            clock;
  logic            reset_n;
  logic [COLS-1:0] keypadCol;
  logic [ROWS-1:0] keypadRow;
  logic [3:0]      key_code;
  logic            key_valid, key_ready, key_held, overflow, ovf_clear;
  logic [15:0]     pressed;

  int checks = 0;
  int errors = 0;

  // Reference model state (values the DUT outputs must hold after each edge).
  int m_phase, m_row, m_acc, m_fkey, m_cand, m_streak, m_code;
  bit m_pend, m_held, m_valid, m_ovf;
  int q[$];

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV),
    .DEBOUNCE_FRAMES(DF), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset_n), .keypadCol(keypadCol), .keypadRow(keypadRow),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    keypadCol = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!keypadRow[r] && pressed[r*COLS+c]) keypadCol[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_row = 0; m_acc = -1; m_fkey = -1; m_pend = 0;
    m_held = 0; m_cand = -1; m_streak = 0;
    q.delete(); m_valid = 0; m_code = 0; m_ovf = 0;
  endtask

  // Held flag plus a streak of identical frames; a completed press streak emits a code.
  task automatic debounce(input int fk, output bit push, output int pkey);
    push = 0; pkey = 0;
    if (!m_held) begin
      if (fk < 0) m_streak = 0;
      else if (m_streak > 0 && fk == m_cand) m_streak++;
      else begin m_cand = fk; m_streak = 1; end
      if (m_streak == DF) begin m_held = 1; m_streak = 0; push = 1; pkey = m_cand; end
    end else begin
      if (fk < 0) begin
        m_streak++;
        if (m_streak == DF) begin m_held = 0; m_streak = 0; end
      end else m_streak = 0;
    end
  endtask

  function automatic bit will_push();
    return m_pend && !m_held && m_fkey >= 0 && m_fkey == m_cand && m_streak == DF - 1;
  endfunction

  task automatic model_edge();
    bit pop, push, drop;
    int pkey, hit;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pop  = m_valid && key_ready;
    push = 0; pkey = 0;
    if (m_pend) debounce(m_fkey, push, pkey);
    drop = push && q.size() == DEPTH && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(pkey);
    if (drop) m_ovf = 1;
    else if (ovf_clear) m_ovf = 0;
    m_valid = (q.size() != 0);
    if (m_valid) m_code = q[0];
    m_pend = 0;
    if (m_phase == SDIV - 1) begin
      hit = -1;
      for (int c = 0; c < COLS; c++)
        if (pressed[m_row*COLS+c] && hit < 0) hit = m_row*COLS + c;
      if (m_row == 0 || m_acc < 0) m_acc = hit;
      if (m_row == ROWS - 1) begin m_fkey = m_acc; m_pend = 1; end
      m_row = (m_row + 1) % ROWS;
    end
    m_phase = (m_phase + 1) % SDIV;
  endtask

  // Single compare point: advance one clock, update the model, check every output.
  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    check("row_drive", keypadRow, (~(1 << m_row)) & ((1 << ROWS) - 1));
    check("key_valid", key_valid, m_valid);
    check("key_held", key_held, m_held);
    check("overflow", overflow, m_ovf);
    if (m_valid) check("key_code", key_code, m_code);
  endtask

  task automatic tap_key(input int code, input bit pop_on_push);
    bit seen = 0;
    pressed = 16'(1) << code;
    repeat (64) begin
      key_ready = pop_on_push && will_push();
      if (key_ready) seen = 1;
      step();
    end
    key_ready = 0;
    pressed = '0;
    repeat (64) step();
    if (pop_on_push) check("push_pop_seen", seen, 1);
  endtask

  task automatic pop_one();
    key_ready = 1;
    step();
    key_ready = 0;
  endtask

  logic [3:0] rot_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int ovf_codes [5] = '{3, 6, 10, 12, 15};
  int fp_codes  [5] = '{1, 4, 7, 11, 14};

  initial begin
    int n, dur, sel;
    bit found;
    reset_n = 0; pressed = '0; key_ready = 0; ovf_clear = 0;
    model_reset();
    step(); step();
    check("rst_row", keypadRow, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1;

    for (int i = 0; i < 4; i++) begin
      repeat (4) step();
      check("rotation", keypadRow, rot_exp[i]);
      check("rot_valid", key_valid, 0);
    end

    pressed = 16'(1) << 9;
    repeat (80) step();
    check("press_code", key_code, 9);
    check("press_valid", key_valid, 1);
    check("press_held", key_held, 1);
    pop_one();
    check("single_push", key_valid, 0);
    pressed = '0;
    repeat (80) step();
    check("release_held", key_held, 0);

    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'(1) << 9 : '0;
      repeat (16) step();
    end
    pressed = '0;
    repeat (64) step();
    check("bounce_valid", key_valid, 0);
    check("bounce_held", key_held, 0);

    for (int i = 0; i < 5; i++) tap_key(ovf_codes[i], 0);
    check("ovf_set", overflow, 1);
    ovf_clear = 1;
    step();
    ovf_clear = 0;
    check("ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", key_code, ovf_codes[i]);
      pop_one();
    end
    check("ovf_drained", key_valid, 0);

    for (int i = 0; i < 5; i++) tap_key(fp_codes[i], i == 4);
    check("fullpp_ovf", overflow, 0);
    for (int i = 1; i < 5; i++) begin
      check("fullpp_order", key_code, fp_codes[i]);
      pop_one();
    end
    check("fullpp_drained", key_valid, 0);

    pressed = 16'(1) << 5;
    found = 0; n = 0;
    while (!found && n < 200) begin
      step();
      n++;
      found = !m_held && m_streak == 2;
    end
    check("midpress_reached", found, 1);
    reset_n = 0;
    step();
    reset_n = 1;
    check("midrst_row", keypadRow, 4'b1110);
    check("midrst_valid", key_valid, 0);
    check("midrst_code", key_code, 0);
    check("midrst_held", key_held, 0);
    repeat (48) step();
    check("midrst_nopush", key_valid, 0);
    check("midrst_noheld", key_held, 0);
    step();
    check("midrst_push", key_valid, 1);
    check("midrst_code5", key_code, 5);
    check("midrst_held5", key_held, 1);
    pressed = '0;
    repeat (64) step();
    pop_one();

    repeat (60) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      pressed = '0;
      else if (sel < 8) pressed = 16'(1) << $urandom_range(0, 15);
      else              pressed = 16'($urandom_range(0, 65535));
      dur = $urandom_range(8, 90);
      repeat (dur) begin
        key_ready = ($urandom_range(0, 3) == 0);
        ovf_clear = ($urandom_range(0, 15) == 0);
        reset_n   = ($urandom_range(0, 599) != 0);
        step();
      end
    end
    reset_n = 1; key_ready = 0; ovf_clear = 0; pressed = '0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
